// File: rtl/bank_mem_arbiter.sv
// bank_mem_arbiter: two-port round-robin arbiter serialising reads/writes onto a four-bank single-port SRAM.
module bank_mem_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 11,
  parameter int BANK_W = 2
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic [1:0]               req_i,
  input  logic [1:0]               we_i,
  input  logic [BANK_W+ADDR_W-1:0] addr0_i,
  input  logic [BANK_W+ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0]        wdata0_i,
  input  logic [DATA_W-1:0]        wdata1_i,
  output logic [1:0]               gnt_o,
  output logic [1:0]               rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     busy_o,
  output logic [BANK_W-1:0]        Sel_Mem,
  output logic                     Eneable,
  output logic                     WriteEneable,
  output logic [ADDR_W-1:0]        Address,
  output logic [DATA_W-1:0]        Data,
  input  logic [DATA_W-1:0]        LineData
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic last_gnt, cmd_we, cmd_port, win;
  logic [BANK_W+ADDR_W-1:0] win_addr;
  // On a tie the port that did not win last time goes next.
  assign win = &req_i ? ~last_gnt : req_i[1];
  assign win_addr = win ? addr1_i : addr0_i;
  assign busy_o = state != IDLE;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state <= IDLE;
      last_gnt <= 1'b1;
      cmd_we <= 1'b0;
      cmd_port <= 1'b0;
      gnt_o <= '0;
      rvalid_o <= '0;
      rdata_o <= '0;
      Sel_Mem <= '0;
      Eneable <= 1'b0;
      WriteEneable <= 1'b1;
      Address <= '0;
      Data <= '0;
    end else begin
      gnt_o <= '0;
      rvalid_o <= '0;
      case (state)
        IDLE:
          if (|req_i) begin
            state <= ACCESS;
            last_gnt <= win;
            cmd_port <= win;
            cmd_we <= we_i[win];
            gnt_o <= {win, ~win};
            Eneable <= 1'b1;
            WriteEneable <= ~we_i[win];
            Sel_Mem <= win_addr[BANK_W+ADDR_W-1:ADDR_W];
            Address <= win_addr[ADDR_W-1:0];
            Data <= win ? wdata1_i : wdata0_i;
          end
        ACCESS: begin
          Eneable <= 1'b0;
          WriteEneable <= 1'b1;
          state <= cmd_we ? IDLE : RESP;
        end
        // Sel_Mem stays put here so the read mux still points at the accessed bank.
        RESP: begin
          rdata_o <= LineData;
          rvalid_o <= {cmd_port, ~cmd_port};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/bank_mem_arbiter.md
# bank_mem_arbiter

Two-port round-robin controller for the four-bank 64-bit data memory (4 × 2048 words, bank-selected, single-ported synchronous SRAM macros behind a bank decoder and read-back mux). It accepts read/write requests from two requesters, port 0 for CPU load/store and port 1 for line refill/DMA. It serialises them onto the single memory port and drives bank select, chip enable, write enable, address and write data. It returns registered read data.

## Interface
Parameters:
- DATA_W, 64, memory word width
- ADDR_W, 11, word index width inside one bank
- BANK_W, 2, bank select width; request address is BANK_W+ADDR_W = 13 bits

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RSTn  in  1  asynchronous, active-low reset
- req_i  in  2  request per port, bit p = port p
- we_i  in  2  1 = write, 0 = read, per port
- addr0_i / addr1_i  in  13  {bank[12:11], index[10:0]} per port
- wdata0_i / wdata1_i  in  64  write data per port
- gnt_o  out  2  one-cycle pulse: request of port p accepted
- rvalid_o  out  2  one-cycle pulse: rdata_o valid for port p
- rdata_o  out  64  registered read data, shared by both ports
- busy_o  out  1  high whenever state ≠ IDLE
- Sel_Mem  out  2  bank select to decoder and read mux
- Eneable  out  1  active-high access enable into bank decoder
- WriteEneable  out  1  active-low SRAM write enable
- Address  out  11  SRAM word index
- Data  out  64  SRAM write data
- LineData  in  64  read mux output from the bank array

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req_i bit is set, the controller picks the winner, latches its we/addr/wdata into command registers, records the port in last_gnt, pulses gnt_o[winner] next cycle and moves to ACCESS. With no request it stays in IDLE.
- Arbitration is round-robin. A single requester always wins. If both request, the winner is the port ≠ last_gnt. last_gnt resets to 1, so port 0 wins the first tie.
- ACCESS (one cycle): Eneable = 1. Sel_Mem = latched bank. Address = latched index. Data = latched wdata. WriteEneable = 0 for a write, 1 for a read. Next state is RESP for a read and IDLE for a write.
- RESP (one cycle, reads only): Eneable = 0 and WriteEneable = 1. Sel_Mem and Address stay held, because the read mux is steered by Sel_Mem. At the edge leaving RESP, LineData is captured into rdata_o. Next state is IDLE, and rvalid_o[port] pulses in the following cycle.
- Outside ACCESS: Eneable = 0 and WriteEneable = 1. Sel_Mem, Address and Data hold their last values.
- rdata_o holds its value until the next read completes.
- Request fields are sampled only in IDLE. A requester keeps req/we/addr/wdata stable until it sees gnt_o, then deasserts or presents a new request. A request withdrawn before sampling is simply not served.
- Requests arriving in ACCESS or RESP wait. A request held through a grant cycle is treated as a new request.

## Timing
- Read: req sampled at edge E0 → gnt_o and ACCESS in cycle 1 → RESP in cycle 2 → rvalid_o and rdata_o in cycle 3 (3 cycles request-to-data).
- In cycle 3 the FSM is already in IDLE, so the next request can be sampled at the end of cycle 3. Read throughput is one every 3 cycles.
- Write: gnt_o and ACCESS in cycle 1; the SRAM writes at the end of cycle 1; the FSM is back in IDLE in cycle 2. Write throughput is one every 2 cycles.
- gnt_o and rvalid_o are never high for both ports in the same cycle.
- Reset (RSTn = 0, asynchronous) forces:
  - state = IDLE, last_gnt = 1
  - gnt_o = 0, rvalid_o = 0, busy_o = 0
  - rdata_o = 0
  - Sel_Mem = 0, Eneable = 0, WriteEneable = 1, Address = 0, Data = 0
- Reset during ACCESS aborts the access. Memory contents at that address are unspecified, and no gnt, rvalid or retry is generated after release.
- Reset release: the first edge with RSTn = 1 may sample requests.

## Test plan
- Reset values: with RSTn low, drive req_i = 2'b11 → every output at its reset value, busy_o = 0 and no gnt_o.
- Single write then read, port 0: write bank 2, index 0x7FF, data 0xDEADBEEF_01234567, then read the same location → gnt_o[0] one cycle after each sample, WriteEneable low only in the write's ACCESS cycle. rvalid_o[0] arrives 3 cycles after the read sample with rdata_o = 0xDEADBEEF_01234567, and Sel_Mem = 2 is held through RESP.
- Bank isolation: write 0x1111…, 0x2222…, 0x3333… and 0x4444… to index 5 of banks 0–3, then read all four → each read returns its own bank's value.
- Contention: hold req_i = 2'b11 for 8 grants after reset → grant order is 0,1,0,1,… with no back-to-back grant to the same port.
- Back-to-back mix: port 1 read and port 0 write issued together, then repeated → no overlap of ACCESS cycles, and rvalid_o only for port 1 with the correct data.
- Reset mid-operation: assert RSTn low during a read's ACCESS → all outputs return to reset values immediately, and no rvalid_o appears after release.
